// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
//   state_t     : arbiter FSM state (IDLE / ISSUE / HOLD)
//   SEL_A/SEL_B : register-select mux encodings, also used as grant IDs
//   DATA_W_DEF / REG_W_DEF : default data and register-specifier widths
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: ALU (A) and load (B) result handshakes plus the
// register-file write port.
//   slave  : arbiter side (takes valids/payloads/wr_stall, drives readies and write port)
//   master : environment side (producers and register file)
interface wb_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              a_valid;
  logic              a_ready;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [REG_W-1:0]  b_reg;
  logic [DATA_W-1:0] b_data;
  logic              wr_stall;
  logic              wr_en;
  logic              wr_sel;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, wr_stall,
    output a_ready, b_ready, wr_en, wr_sel, wr_reg, wr_data
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, wr_stall,
    input  a_ready, b_ready, wr_en, wr_sel, wr_reg, wr_data
  );
endinterface

// File: rtl/wb_rr_pick.sv
// Two-way round-robin grant.
//   req[1:0] : request vector (bit 0 = A, bit 1 = B)
//   last     : port granted on the last completed transfer (SEL_A / SEL_B)
//   gnt[1:0] : one-hot grant; a sole requester wins, on a tie the port
//              that was not granted last wins
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | (last == SEL_B));
  assign gnt[1] = req[1] & (~req[0] | (last == SEL_A));
endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges ALU (A) and load (B) results onto a single
// register-file write port with round-robin fairness and one-cycle latency.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : A/B valid-ready handshakes, wr_stall in, write port out
//   conflict_cnt: saturating count of cycles with both valids high
//                 (present only when WB_ARB_CONFLICT_CNT_EN is defined)
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_CONFLICT_CNT_EN
  ,
  output logic [7:0]         conflict_cnt
`endif
);

  state_t            state;
  logic              last_grant;
  logic [1:0]        gnt;
  logic              can_accept;
  logic              xfer_a, xfer_b, xfer;
  logic              sel_q;
  logic [REG_W-1:0]  reg_q;
  logic [DATA_W-1:0] data_q;

  wb_rr_pick u_pick (
    .req  ({bus.b_valid, bus.a_valid}),
    .last (last_grant),
    .gnt  (gnt)
  );

  // Accept only when the output slot is free or retiring this cycle.
  // rst_n gates the readies so they drop the instant reset asserts.
  assign can_accept  = rst_n && (state != HOLD) && !bus.wr_stall;
  assign bus.a_ready = gnt[0] & can_accept;
  assign bus.b_ready = gnt[1] & can_accept;

  assign xfer_a = bus.a_valid & bus.a_ready;
  assign xfer_b = bus.b_valid & bus.b_ready;
  assign xfer   = xfer_a | xfer_b;

  assign bus.wr_en   = (state == ISSUE) && !bus.wr_stall;
  assign bus.wr_sel  = sel_q;
  assign bus.wr_reg  = reg_q;
  assign bus.wr_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SEL_B;
      sel_q      <= SEL_A;
      reg_q      <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE:    if (xfer) state <= ISSUE;
        ISSUE:   if (bus.wr_stall) state <= HOLD;
                 else if (!xfer)   state <= IDLE;
        HOLD:    if (!bus.wr_stall) state <= ISSUE;
        default: state <= IDLE;
      endcase
      // A transfer only happens when the slot is free or retiring,
      // so overwriting the held write here is always safe.
      if (xfer) begin
        last_grant <= xfer_b ? SEL_B : SEL_A;
        sel_q      <= xfer_b ? SEL_B : SEL_A;
        reg_q      <= xfer_b ? bus.b_reg  : bus.a_reg;
        data_q     <= xfer_b ? bus.b_data : bus.a_data;
      end
    end
  end

`ifdef WB_ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (bus.a_valid && bus.b_valid && conflict_cnt != 8'hFF)
      conflict_cnt <= conflict_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter. Define WB_ARB_CONFLICT_CNT_EN to
// also exercise the conflict counter.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  wb_port_arbiter_if #(.DATA_W(16), .REG_W(3)) bus ();

`ifdef WB_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  wb_port_arbiter #(.DATA_W(16), .REG_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic sel,
                        input logic [2:0] r, input logic [15:0] d);
    chk({tag, ".wr_en"},   {31'd0, bus.wr_en},  {31'd0, en});
    chk({tag, ".wr_sel"},  {31'd0, bus.wr_sel}, {31'd0, sel});
    chk({tag, ".wr_reg"},  {29'd0, bus.wr_reg}, {29'd0, r});
    chk({tag, ".wr_data"}, {16'd0, bus.wr_data}, {16'd0, d});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.a_valid = 1'b1; bus.a_reg = 3'd0; bus.a_data = 16'h0;
    bus.b_valid = 1'b0; bus.b_reg = 3'd0; bus.b_data = 16'h0;
    bus.wr_stall = 1'b0;

    // Reset state, with a valid present to prove readies are forced low
    #3;
    chk_wr("reset", 1'b0, 1'b0, 3'd0, 16'h0);
    chk("reset.a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("reset.b_ready", {31'd0, bus.b_ready}, 32'd0);
`ifdef WB_ARB_CONFLICT_CNT_EN
    chk("reset.conflict_cnt", {24'd0, conflict_cnt}, 32'd0);
`endif
    tick();
    bus.a_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single A transfer, one-cycle latency
    bus.a_valid = 1'b1; bus.a_reg = 3'd3; bus.a_data = 16'h1234;
    #1;
    chk("single.a_ready", {31'd0, bus.a_ready}, 32'd1);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk_wr("single", 1'b1, 1'b0, 3'd3, 16'h1234);
    tick();
    chk("single.retire", {31'd0, bus.wr_en}, 32'd0);

    // Tie after reset: A first, then alternate one write per cycle
    rst_n = 1'b0; #1; rst_n = 1'b1;
    bus.a_valid = 1'b1; bus.a_reg = 3'd1; bus.a_data = 16'hA001;
    bus.b_valid = 1'b1; bus.b_reg = 3'd5; bus.b_data = 16'hB005;
    #1;
    chk("tie.a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk("tie.b_ready", {31'd0, bus.b_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) chk_wr("tie_a", 1'b1, 1'b0, 3'd1, 16'hA001);
      else            chk_wr("tie_b", 1'b1, 1'b1, 3'd5, 16'hB005);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    chk("tie.idle", {31'd0, bus.wr_en}, 32'd0);

    // Stall: B held through 3 stalled cycles, A waits without being dropped
    bus.b_valid = 1'b1; bus.b_reg = 3'd2; bus.b_data = 16'hBEEF;
    #1;
    chk("stall.b_ready", {31'd0, bus.b_ready}, 32'd1);
    tick();
    bus.b_valid = 1'b0; bus.wr_stall = 1'b1;
    bus.a_valid = 1'b1; bus.a_reg = 3'd6; bus.a_data = 16'h0606;
    #1;
    chk_wr("stall0", 1'b0, 1'b1, 3'd2, 16'hBEEF);
    chk("stall0.a_ready", {31'd0, bus.a_ready}, 32'd0);
    tick();
    chk_wr("stall1", 1'b0, 1'b1, 3'd2, 16'hBEEF);
    chk("stall1.a_ready", {31'd0, bus.a_ready}, 32'd0);
    tick();
    chk_wr("stall2", 1'b0, 1'b1, 3'd2, 16'hBEEF);
    chk("stall2.a_ready", {31'd0, bus.a_ready}, 32'd0);
    bus.wr_stall = 1'b0;
    #1;
    chk("hold_release.wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("hold_release.a_ready", {31'd0, bus.a_ready}, 32'd0);
    tick();
    chk_wr("stall_write", 1'b1, 1'b1, 3'd2, 16'hBEEF);
    chk("b2b.a_ready", {31'd0, bus.a_ready}, 32'd1);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk_wr("b2b_a", 1'b1, 1'b0, 3'd6, 16'h0606);
    tick();
    chk("b2b.idle", {31'd0, bus.wr_en}, 32'd0);

    // Reset during HOLD discards the held write
    bus.b_valid = 1'b1; bus.b_reg = 3'd7; bus.b_data = 16'h7777;
    tick();
    bus.b_valid = 1'b0; bus.wr_stall = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_wr("rst_hold", 1'b0, 1'b0, 3'd0, 16'h0);
    rst_n = 1'b1; bus.wr_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_hold.no_write", {31'd0, bus.wr_en}, 32'd0);
    end

    // Same destination on a tie: A first (post-reset), then B, both to reg 4
    bus.a_valid = 1'b1; bus.a_reg = 3'd4; bus.a_data = 16'h0001;
    bus.b_valid = 1'b1; bus.b_reg = 3'd4; bus.b_data = 16'h0002;
    #1;
    chk("samedst.a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk("samedst.b_ready", {31'd0, bus.b_ready}, 32'd0);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk_wr("samedst_a", 1'b1, 1'b0, 3'd4, 16'h0001);
    chk("samedst.b_ready2", {31'd0, bus.b_ready}, 32'd1);
    tick();
    bus.b_valid = 1'b0;
    #1;
    chk_wr("samedst_b", 1'b1, 1'b1, 3'd4, 16'h0002);
    tick();
    chk("samedst.idle", {31'd0, bus.wr_en}, 32'd0);

`ifdef WB_ARB_CONFLICT_CNT_EN
    // Conflict counter saturates at 255
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("conflict_cnt.sat", {24'd0, conflict_cnt}, 32'd255);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
